neuron_mac: RTL and testbench

//  Sequential multiply-accumulate stage for one MLP neuron: streams N_INPUTS signed
//  (x, w) pairs, adds them to a preloaded bias and emits a 21-bit signed pre-activation sum.

---
 rtl/neuron_mac.sv | 152 +++++++++++++++
 tb/tb_neuron_mac.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// neuron_mac: sequential multiply-accumulate for one MLP neuron.
// Streams N_INPUTS signed (x, w) pairs into a bias-preloaded accumulator and
// presents the 21-bit pre-activation sum with a one-cycle out_valid strobe.
//
// state | meaning
// IDLE  | waiting for start; accumulator cleared or holding stale partials
// ACCUM | accepting (x, w) beats until N_INPUTS products are summed
// DONE  | acc_out holds the new result; out_valid pulses for this cycle
module neuron_mac #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 21,
    parameter int N_INPUTS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  acc_out
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_out_q, acc_out_d;

    logic                      beat;
    logic                      last_beat;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_sum;

    // Full-width signed product, sign-extended into the accumulator width;
    // the sum wraps modulo 2^ACC_W.
    assign prod     = x_in * w_in;
    assign prod_ext = ACC_W'(prod);
    assign acc_sum  = acc_q + prod_ext;

    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear always returns to IDLE and beats any start.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = ACCUM;
                ACCUM:   if (last_beat) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore-style outputs, gated by clear so an aborting cycle neither accepts
    // a beat nor announces a result.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = !clear;
                busy     = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = !clear;
            end
            default: begin
                in_ready  = 1'b0;
                busy      = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next values: bias preload, accumulate on beats, capture the
    // final sum into acc_out on the last beat; clear zeroes the partials only.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        acc_out_d = acc_out_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d = bias;
                        cnt_d = '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (last_beat) begin
                        acc_out_d = acc_sum;
                    end
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            acc_out_q <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            acc_out_q <= acc_out_d;
        end
    end

    assign acc_out = acc_out_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: stimulus pushes expected results (value and
// the cycle they must appear in), a negedge monitor pops and compares on out_valid.
module tb_neuron_mac;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 21;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     clear;
    logic signed [ACC_W-1:0]  bias;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] w_in;
    logic                     busy;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  acc_out;

    typedef struct {
        logic [ACC_W-1:0] val;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    neuron_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .N_INPUTS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .busy      (busy),
        .out_valid (out_valid),
        .acc_out   (acc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: every out_valid must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out_valid: got acc_out 0x%0h at cycle %0d, none expected",
                         acc_out, cyc);
            end else begin
                e = sb.pop_front();
                if (acc_out !== e.val) begin
                    n_err++;
                    $display("FAIL acc_out: got 0x%0h expected 0x%0h", acc_out, e.val);
                end
                if (e.due >= 0) begin
                    n_cmp++;
                    if (cyc != e.due) begin
                        n_err++;
                        $display("FAIL out_valid_cycle: got cycle %0d expected cycle %0d", cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    // One full neuron: toggle=1 offers a pair only on odd cycles after start,
    // extra_start pulses start mid-ACCUM (must be ignored).
    task automatic run_neuron(input logic signed [ACC_W-1:0] b,
                              input logic signed [DATA_W-1:0] x,
                              input logic signed [DATA_W-1:0] w,
                              input bit toggle, input bit extra_start,
                              input logic signed [ACC_W-1:0] expv);
        int e;
        int nb;
        int j;
        exp_t item;
        @(posedge clk); #1;
        start = 1'b1;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
        bias  = 21'sd999;
        e = cyc;
        item.val = expv;
        item.due = e + (toggle ? 63 : 32);
        sb.push_back(item);
        check("busy_in_accum", {31'b0, busy}, 32'd1);
        nb = 0;
        j  = 1;
        while (nb < 32) begin
            in_valid = toggle ? j[0] : 1'b1;
            x_in     = x;
            w_in     = w;
            start    = extra_start && (j == 10);
            if (in_valid) nb++;
            @(posedge clk); #1;
            j++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        drain();
        @(posedge clk); #1;
        check("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        bias     = '0;
        in_valid = 1'b0;
        x_in     = '0;
        w_in     = '0;
        #2;
        check("reset_acc_out", {11'b0, acc_out}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        #10;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // 32 x (1*1), bias 0, in_valid held
        run_neuron(21'sd0, 8'sd1, 8'sd1, 1'b0, 1'b0, 21'sd32);

        // async reset mid-ACCUM after 5 beats
        @(posedge clk); #1;
        start = 1'b1;
        bias  = 21'sd77;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        x_in     = 8'sd2;
        w_in     = 8'sd3;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midreset_acc_out", {11'b0, acc_out}, 32'd0);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_in_ready", {31'b0, in_ready}, 32'd0);
        check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("post_reset_busy", {31'b0, busy}, 32'd0);

        // extreme negative x negative products, then mixed sign
        run_neuron(21'sd0, -8'sd128, -8'sd128, 1'b0, 1'b0, 21'sd524288);
        run_neuron(21'sd0, -8'sd128, 8'sd127, 1'b0, 1'b0, -21'sd520192);

        // negative bias
        run_neuron(-21'sd100, 8'sd3, -8'sd2, 1'b0, 1'b0, -21'sd292);
        check("neg_result_hex", {11'b0, acc_out}, 32'h1FFEDC);

        // in_valid toggling with a stray start mid-ACCUM
        run_neuron(21'sd0, 8'sd1, 8'sd1, 1'b1, 1'b1, 21'sd32);

        // clear after 10 beats
        @(posedge clk); #1;
        start = 1'b1;
        bias  = 21'sd0;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        x_in     = 8'sd1;
        w_in     = 8'sd1;
        repeat (10) @(posedge clk);
        #1;
        clear = 1'b1;
        #1;
        check("clear_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", {31'b0, busy}, 32'd0);
        check("clear_acc_out_kept", {11'b0, acc_out}, 32'd32);
        repeat (5) @(posedge clk);

        run_neuron(21'sd5, 8'sd1, 8'sd1, 1'b0, 1'b0, 21'sd37);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
